// File: rtl/hd_program_streamer_pkg.sv
// Shared definitions for the HD->instruction-memory load path: FSM encoding, control codes
// and the payload length clamp.
package hd_program_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam logic [2:0] CTRL_IDLE   = 3'b000;
  localparam logic [2:0] CTRL_ACTIVE = 3'b001;

  function automatic logic [7:0] clamp_len(input logic [7:0] hdr_len, input int unsigned max_words);
    if (32'(hdr_len) > max_words) return 8'(max_words);
    return hdr_len;
  endfunction

endpackage

// File: rtl/hd_program_streamer_hd_storage.sv
// HD array: 1R1W RAM with a registered (synchronous) read port and read-first behaviour.
module hd_storage #(
  parameter int DATA_W   = 32,
  parameter int HD_DEPTH = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [HD_DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; both accesses use <= so a
  // same-address write in the same cycle returns the old word.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/hd_program_streamer.sv
// Streams a header-prefixed program image from the HD array to the instruction memory.
// Optional trailer checksum check is built when HD_CHECKSUM_EN is defined.
module hd_program_streamer
  import hd_program_streamer_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          HD_DEPTH       = 1024,
  parameter int          ADDR_W         = 10,
  parameter int unsigned MAX_PROG_WORDS = 201
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic              hd_we,
  input  logic [ADDR_W-1:0] hd_waddr,
  input  logic [DATA_W-1:0] hd_wdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [2:0]        save_ctrl,
  output logic [2:0]        end_of_read,
  output logic              busy,
  output logic [7:0]        words_sent,
  output logic              checksum_err
);

  state_t            r_state, w_state_nxt;
  logic              r_hdr_ph;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_idx;
  logic [DATA_W-1:0] w_rdata;
  logic [7:0]        w_hdr_len;
  logic              w_pay;

  hd_storage #(.DATA_W(DATA_W), .HD_DEPTH(HD_DEPTH), .ADDR_W(ADDR_W)) u_hd (
    .clock   (clock),
    .i_we    (hd_we),
    .i_waddr (hd_waddr),
    .i_wdata (hd_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  // The header read takes two HDR cycles (address, then data), which puts the first
  // payload word on the outputs at the third edge after start.
  assign w_hdr_len = clamp_len(w_rdata[7:0], MAX_PROG_WORDS);
  assign w_pay     = (r_state == ST_STREAM) && (r_idx < r_len);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next state is defaulted first so no path through the case leaves it unassigned.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_HDR;
      ST_HDR:    if (r_hdr_ph) w_state_nxt = (w_hdr_len == 8'd0) ? ST_DONE : ST_STREAM;
`ifdef HD_CHECKSUM_EN
      ST_STREAM: if (r_idx == r_len) w_state_nxt = ST_DONE;
`else
      ST_STREAM: if (r_idx == r_len - 8'd1) w_state_nxt = ST_DONE;
`endif
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef HD_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_bad, r_cerr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum  <= '0;
      r_bad  <= 1'b0;
      r_cerr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_sum  <= '0;
          r_bad  <= 1'b0;
          r_cerr <= 1'b0;
        end
        ST_STREAM: begin
          if (w_pay) r_sum <= r_sum + w_rdata;
          else       r_bad <= (w_rdata != r_sum);
        end
        ST_DONE: r_cerr <= r_bad;
        default: ;
      endcase
    end
  end

  assign checksum_err = r_cerr;
`else
  assign checksum_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hdr_ph    <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      instr_out   <= '0;
      save_ctrl   <= CTRL_IDLE;
      end_of_read <= CTRL_ACTIVE;
      busy        <= 1'b0;
      words_sent  <= '0;
    end else begin
      save_ctrl <= CTRL_IDLE;
      case (r_state)
        ST_IDLE: if (start) begin
          r_addr      <= prog_base;
          r_hdr_ph    <= 1'b0;
          r_idx       <= '0;
          words_sent  <= '0;
          busy        <= 1'b1;
          end_of_read <= CTRL_IDLE;
        end
        ST_HDR: begin
          r_hdr_ph <= 1'b1;
          r_addr   <= r_addr + 1'b1;
          r_len    <= w_hdr_len;
        end
        ST_STREAM: begin
          r_addr <= r_addr + 1'b1;
          r_idx  <= r_idx + 8'd1;
          if (w_pay) begin
            instr_out  <= w_rdata;
            save_ctrl  <= CTRL_ACTIVE;
            words_sent <= words_sent + 8'd1;
          end
        end
        ST_DONE: begin
          end_of_read <= CTRL_ACTIVE;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_program_streamer.sv
// Directed self-checking bench for hd_program_streamer (checksum cases only with HD_CHECKSUM_EN).
module tb_hd_program_streamer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  prog_base = '0;
  logic        hd_we = 1'b0;
  logic [9:0]  hd_waddr = '0;
  logic [31:0] hd_wdata = '0;
  logic [31:0] instr_out;
  logic [2:0]  save_ctrl, end_of_read;
  logic        busy, checksum_err;
  logic [7:0]  words_sent;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_words [256];

  hd_program_streamer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .prog_base    (prog_base),
    .hd_we        (hd_we),
    .hd_waddr     (hd_waddr),
    .hd_wdata     (hd_wdata),
    .instr_out    (instr_out),
    .save_ctrl    (save_ctrl),
    .end_of_read  (end_of_read),
    .busy         (busy),
    .words_sent   (words_sent),
    .checksum_err (checksum_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hd_write(input logic [9:0] a, input logic [31:0] d);
    hd_we = 1'b1; hd_waddr = a; hd_wdata = d;
    @(negedge clock);
    hd_we = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/instr"}, instr_out, 32'h0);
    check({tag, "/save"}, 32'(save_ctrl), 32'h0);
    check({tag, "/eor"}, 32'(end_of_read), 32'h1);
    check({tag, "/busy"}, 32'(busy), 32'h0);
    check({tag, "/words"}, 32'(words_sent), 32'h0);
    check({tag, "/cerr"}, 32'(checksum_err), 32'h0);
  endtask

  // Start a transfer at a negedge and watch it until busy drops.
  // Sample k=0 is the cycle right after the start edge; payload must begin at k=3.
  task automatic run_xfer(input string tag, input logic [9:0] base, input int exp_len,
                          input int exp_cerr, input int inj_k);
    int k, first, last, cnt, extra;
    bit overlap;
    first = -1; last = -1; cnt = 0; overlap = 0; extra = 0;
`ifdef HD_CHECKSUM_EN
    if (exp_len > 0) extra = 1;
`endif
    prog_base = base; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "/busy_on"}, 32'(busy), 32'h1);
    check({tag, "/eor_low"}, 32'(end_of_read), 32'h0);
    k = 0;
    while (busy && k < 600) begin
      if (save_ctrl == 3'b001) begin
        if (first < 0) first = k;
        last = k;
        if (cnt < 256) check({tag, "/word"}, instr_out, exp_words[cnt]);
        cnt++;
      end
      if (save_ctrl == 3'b001 && end_of_read == 3'b001) overlap = 1'b1;
      start = (k == inj_k);
      if (k == inj_k) prog_base = base + 10'd24;
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    check({tag, "/no_timeout"}, 32'(k < 600), 32'h1);
    check({tag, "/busy_cycles"}, 32'(k), 32'(3 + exp_len + extra));
    check({tag, "/first"}, 32'(first), (exp_len > 0) ? 32'd3 : 32'hFFFF_FFFF);
    check({tag, "/last"}, 32'(last), (exp_len > 0) ? 32'(2 + exp_len) : 32'hFFFF_FFFF);
    check({tag, "/pulses"}, 32'(cnt), 32'(exp_len));
    check({tag, "/words_sent"}, 32'(words_sent), 32'(exp_len));
    check({tag, "/eor_end"}, 32'(end_of_read), 32'h1);
    check({tag, "/save_end"}, 32'(save_ctrl), 32'h0);
    check({tag, "/overlap"}, 32'(overlap), 32'h0);
    if (exp_cerr >= 0) check({tag, "/cerr"}, 32'(checksum_err), 32'(exp_cerr));
  endtask

  initial begin
    int pulses, def_cerr;
    def_cerr = 0;
`ifdef HD_CHECKSUM_EN
    def_cerr = -1;
`endif
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clock);

    // Images: base 16 (3 words), base 40 (len 0 with upper header bits set),
    // base 200 (header 255), base 1022 (wrap), base 500 (reset abort).
    hd_write(10'd16, 32'h0000_0003);
    hd_write(10'd17, 32'hAAAA_0001);
    hd_write(10'd18, 32'hBBBB_0002);
    hd_write(10'd19, 32'hCCCC_0003);
    hd_write(10'd40, 32'h1234_5600);
    hd_write(10'd200, 32'h0000_00FF);
    for (int i = 0; i < 255; i++) hd_write(10'(201 + i), 32'h5000_0000 + 32'(i));
    hd_write(10'd1022, 32'h0000_0002);
    hd_write(10'd1023, 32'hDEAD_1023);
    hd_write(10'd0, 32'hBEEF_0000);
    hd_write(10'd500, 32'h0000_000A);
    for (int i = 0; i < 10; i++) hd_write(10'(501 + i), 32'h7700_0000 + 32'(i));

    exp_words[0] = 32'hAAAA_0001;
    exp_words[1] = 32'hBBBB_0002;
    exp_words[2] = 32'hCCCC_0003;
    run_xfer("basic", 10'd16, 3, def_cerr, -1);

    run_xfer("len0", 10'd40, 0, 0, -1);

    for (int i = 0; i < 201; i++) exp_words[i] = 32'h5000_0000 + 32'(i);
    run_xfer("clamp", 10'd200, 201, def_cerr, -1);

    exp_words[0] = 32'hDEAD_1023;
    exp_words[1] = 32'hBEEF_0000;
    run_xfer("wrap", 10'd1022, 2, def_cerr, -1);

    exp_words[0] = 32'hAAAA_0001;
    exp_words[1] = 32'hBBBB_0002;
    exp_words[2] = 32'hCCCC_0003;
    run_xfer("start_busy", 10'd16, 3, def_cerr, 4);
    repeat (3) @(negedge clock);
    check("start_busy/stay_idle", 32'(busy), 32'h0);

    // Reset in the middle of a 10-word stream.
    prog_base = 10'd500; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    check("abort/streaming", 32'(save_ctrl), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("abort");
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (save_ctrl != 3'b000) pulses++;
    end
    check("abort/no_pulses", 32'(pulses), 32'h0);

`ifdef HD_CHECKSUM_EN
    hd_write(10'd600, 32'h0000_0003);
    hd_write(10'd601, 32'd1);
    hd_write(10'd602, 32'd2);
    hd_write(10'd603, 32'd3);
    hd_write(10'd604, 32'd6);
    hd_write(10'd610, 32'h0000_0003);
    hd_write(10'd611, 32'd1);
    hd_write(10'd612, 32'd2);
    hd_write(10'd613, 32'd3);
    hd_write(10'd614, 32'd7);
    exp_words[0] = 32'd1;
    exp_words[1] = 32'd2;
    exp_words[2] = 32'd3;
    run_xfer("csum_ok", 10'd600, 3, 0, -1);
    run_xfer("csum_bad", 10'd610, 3, 1, -1);
    run_xfer("csum_clear", 10'd600, 3, 0, -1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
